mem_access_arbiter: RTL and testbench
=====================================

Name: mem_access_arbiter

Overview:
Sole master of the exmemory port. Shares it between two requesters: port 0 (CPU memory stage) and port 1 (debug/program loader). Arbitrates round-robin and sequences each access through a small FSM. Sub-word stores become read-modify-write (RMW) word cycles, because the RAM only accepts whole-word writes. Rejects illegal accesses (misaligned word, write to ROM, bad mode) without touching memory.

Parameters:
WIDTH, 32, data width (fixed by exmemory)
ADDR_WIDTH, 16, byte address width; region = addr[15:12] (0 ROM, 1 RAM, F I/O)

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-low
req_valid  in  2  per-port request valid (bit n = port n)
req_ready  out  2  per-port accept strobe, one-hot or zero
req_write0 / req_write1  in  1  1 = store
req_mode0 / req_mode1  in  2  00 word, 01 byte signed load, 10 byte unsigned load/byte store
req_addr0 / req_addr1  in  ADDR_WIDTH  byte address
req_wdata0 / req_wdata1  in  WIDTH  store data (byte stores use [7:0])
rsp_valid  out  2  per-port one-cycle completion strobe
rsp_err  out  1  completion is an error; qualified by rsp_valid
rsp_rdata  out  WIDTH  load data; qualified by rsp_valid
MemWrite  out  1  to exmemory
MemMode  out  2  to exmemory
memAddr  out  ADDR_WIDTH  to exmemory
memWriteData  out  WIDTH  to exmemory
memReadData  in  WIDTH  from exmemory; combinational read

Behaviour:
- Reset (reset==0 at posedge): state=IDLE, last_grant=1 (port 0 wins the first tie), req_ready=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, MemWrite=0, MemMode=0, memAddr=0, memWriteData=0.
- Reset mid-operation aborts the access: no response, and MemWrite is low from the following cycle. The top level drives the exmemory reset pin with ~reset.
- Memory outputs are decoded from state plus the latched request. They are 0 in IDLE, ERR and RESP.
- IDLE: if any req_valid, grant one port.
  - Only one valid: grant that port.
  - Both valid: grant the port != last_grant.
  - req_ready[g] is high combinationally in IDLE for the granted port. The transfer completes at that edge; the controller latches write, mode, addr, wdata and g.
  - Next state: ERR if illegal; RMW_RD if byte store; otherwise ACCESS.
- Illegal requests:
  - mode==11;
  - mode==00 with addr[1:0]!=0;
  - write with addr[15:12]==0 (ROM);
  - write with mode==01.
- ACCESS (1 cycle): memAddr=addr, MemMode=mode, MemWrite=write, memWriteData=wdata. For loads, rdata_q<=memReadData at the edge. Next: RESP.
- RMW_RD (1 cycle): memAddr={addr[15:2],2'b00}, MemMode=00, MemWrite=0; word_q<=memReadData. Next: RMW_WR.
- RMW_WR (1 cycle): same memAddr, MemMode=00, MemWrite=1. memWriteData=word_q with byte lane addr[1:0] (lane 0 = bits 7:0) replaced by wdata[7:0]. Next: RESP.
- Byte store to I/O (addr[15:12]==F) follows the same RMW sequence; memory treats it as an I/O write.
- RESP: rsp_valid[g]=1, rsp_err=0, rsp_rdata = rdata_q for loads, 0 for stores; last_grant<=g. Next: IDLE.
- ERR: rsp_valid[g]=1, rsp_err=1, rsp_rdata=0; last_grant<=g. Next: IDLE. No memory cycle is issued.
- Latency from the accept edge to rsp_valid high:
  - 2 cycles for load or word store;
  - 3 cycles for byte store;
  - 1 cycle for error.
- Throughput: one request per port in flight; the next accept happens in the IDLE cycle after RESP/ERR. A requester may hold req_valid continuously.
- req_* inputs are ignored outside IDLE. Changing an unaccepted request while valid is legal.
- Loads from ROM, RAM or I/O regions are always legal.

Test Plan:
- Word store/load: port0 stores 0xDEADBEEF to 0x1000 → MemWrite high for exactly 1 cycle, rsp_valid[0] 2 cycles after accept. Port0 then loads 0x1000 → rsp_rdata=0xDEADBEEF, rsp_err=0.
- Byte RMW: RAM 0x1004 holds 0x11223344; port1 byte store 0xAB to 0x1006 → RMW_RD addr 0x1004, RMW_WR data 0x11AB3344. A later signed byte load of 0x1006 returns 0xFFFFFFAB; an unsigned byte load returns 0x000000AB.
- Round-robin: both ports hold valid with loads. Grants alternate 0,1,0,1 with the first grant to port 0; no port ever receives two consecutive grants while the other is waiting.
- Errors: word load at 0x1002, store to 0x0010, and mode=11 each → rsp_valid + rsp_err 1 cycle after accept, MemWrite never asserted, memAddr stays 0.
- Reset mid-RMW: reset=0 during RMW_RD → next cycle all outputs 0, no RMW_WR write, RAM word unchanged; a fresh request after reset=1 completes normally.
- Back-to-back: port0 valid held for 3 word loads of 0x0000, 0x0004, 0x0008 (ROM) → three responses returning ROM words, one every 3 cycles.

Source files
------------

// File: rtl/mem_access_arbiter.sv
// Two-port round-robin arbiter owning the exmemory port.
// Byte stores become read-modify-write word cycles; illegal requests never touch memory.
module mem_access_arbiter #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic                  req_write0,
  input  logic                  req_write1,
  input  logic [1:0]            req_mode0,
  input  logic [1:0]            req_mode1,
  input  logic [ADDR_WIDTH-1:0] req_addr0,
  input  logic [ADDR_WIDTH-1:0] req_addr1,
  input  logic [WIDTH-1:0]      req_wdata0,
  input  logic [WIDTH-1:0]      req_wdata1,
  output logic [1:0]            rsp_valid,
  output logic                  rsp_err,
  output logic [WIDTH-1:0]      rsp_rdata,
  output logic                  MemWrite,
  output logic [1:0]            MemMode,
  output logic [ADDR_WIDTH-1:0] memAddr,
  output logic [WIDTH-1:0]      memWriteData,
  input  logic [WIDTH-1:0]      memReadData
);

  typedef enum logic [2:0] {
    IDLE,
    ACCESS,
    RMW_RD,
    RMW_WR,
    RESP,
    ERR
  } state_t;

  state_t                state;
  logic                  lastGrant;
  logic                  grantQ;
  logic                  writeQ;
  logic [ADDR_WIDTH-1:0] addrQ;
  logic [7:0]            byteQ;

  logic                  grantSel;
  logic                  selWrite;
  logic [1:0]            selMode;
  logic [ADDR_WIDTH-1:0] selAddr;
  logic [WIDTH-1:0]      selWdata;
  logic                  selIllegal;
  logic                  selByteSt;

  function automatic logic [1:0] portVec(input logic g);
    return g ? 2'b10 : 2'b01;
  endfunction

  function automatic logic isIllegal(
    input logic                  w,
    input logic [1:0]            m,
    input logic [ADDR_WIDTH-1:0] a
  );
    logic [3:0] region;
    region = a[ADDR_WIDTH-1 -: 4];
    return (m == 2'b11)
        || (m == 2'b00 && a[1:0] != 2'b00)
        || (w && region == 4'h0)
        || (w && m == 2'b01);
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] wordAddr(
    input logic [ADDR_WIDTH-1:0] a
  );
    return {a[ADDR_WIDTH-1:2], 2'b00};
  endfunction

  function automatic logic [WIDTH-1:0] mergeByte(
    input logic [WIDTH-1:0] word,
    input logic [1:0]       lane,
    input logic [7:0]       b
  );
    logic [WIDTH-1:0] r;
    r = word;
    r[{lane, 3'b000} +: 8] = b;
    return r;
  endfunction

  // Lone requester wins; on a tie the port not served last wins.
  always_comb begin
    grantSel = 1'b0;
    unique case (req_valid)
      2'b10:   grantSel = 1'b1;
      2'b11:   grantSel = ~lastGrant;
      default: grantSel = 1'b0;
    endcase
  end

  assign selWrite   = grantSel ? req_write1 : req_write0;
  assign selMode    = grantSel ? req_mode1  : req_mode0;
  assign selAddr    = grantSel ? req_addr1  : req_addr0;
  assign selWdata   = grantSel ? req_wdata1 : req_wdata0;
  assign selIllegal = isIllegal(selWrite, selMode, selAddr);
  assign selByteSt  = selWrite && selMode == 2'b10;

  assign req_ready = (state == IDLE && |req_valid)
                   ? portVec(grantSel) : 2'b00;

  // Outputs are registered for the state being entered, so each
  // state presents its memory cycle or response for exactly one cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      lastGrant    <= 1'b1;
      grantQ       <= 1'b0;
      writeQ       <= 1'b0;
      addrQ        <= '0;
      byteQ        <= '0;
      rsp_valid    <= '0;
      rsp_err      <= 1'b0;
      rsp_rdata    <= '0;
      MemWrite     <= 1'b0;
      MemMode      <= '0;
      memAddr      <= '0;
      memWriteData <= '0;
    end else begin
      rsp_valid    <= '0;
      rsp_err      <= 1'b0;
      rsp_rdata    <= '0;
      MemWrite     <= 1'b0;
      MemMode      <= '0;
      memAddr      <= '0;
      memWriteData <= '0;
      unique case (state)
        IDLE: begin
          if (|req_valid) begin
            grantQ <= grantSel;
            writeQ <= selWrite;
            addrQ  <= selAddr;
            byteQ  <= selWdata[7:0];
            if (selIllegal) begin
              state     <= ERR;
              rsp_valid <= portVec(grantSel);
              rsp_err   <= 1'b1;
            end else if (selByteSt) begin
              state   <= RMW_RD;
              memAddr <= wordAddr(selAddr);
            end else begin
              state        <= ACCESS;
              memAddr      <= selAddr;
              MemMode      <= selMode;
              MemWrite     <= selWrite;
              memWriteData <= selWdata;
            end
          end
        end
        ACCESS: begin
          state     <= RESP;
          rsp_valid <= portVec(grantQ);
          rsp_rdata <= writeQ ? '0 : memReadData;
        end
        RMW_RD: begin
          state        <= RMW_WR;
          memAddr      <= wordAddr(addrQ);
          MemWrite     <= 1'b1;
          memWriteData <= mergeByte(memReadData, addrQ[1:0], byteQ);
        end
        RMW_WR: begin
          state     <= RESP;
          rsp_valid <= portVec(grantQ);
        end
        RESP: begin
          state     <= IDLE;
          lastGrant <= grantQ;
        end
        ERR: begin
          state     <= IDLE;
          lastGrant <= grantQ;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Scoreboard bench for mem_access_arbiter with a behavioural exmemory.
// Expected responses come from a reference memory updated at accept time.
module tb_mem_access_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        v0 = 1'b0, v1 = 1'b0;
  logic        w0 = 1'b0, w1 = 1'b0;
  logic [1:0]  m0 = '0, m1 = '0;
  logic [15:0] a0 = '0, a1 = '0;
  logic [31:0] d0 = '0, d1 = '0;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [1:0]  rsp_valid;
  logic        rsp_err;
  logic [31:0] rsp_rdata;
  logic        MemWrite;
  logic [1:0]  MemMode;
  logic [15:0] memAddr;
  logic [31:0] memWriteData;
  logic [31:0] memReadData;

  assign req_valid = {v1, v0};

  always #5 clk = ~clk;

  mem_access_arbiter dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write0   (w0),
    .req_write1   (w1),
    .req_mode0    (m0),
    .req_mode1    (m1),
    .req_addr0    (a0),
    .req_addr1    (a1),
    .req_wdata0   (d0),
    .req_wdata1   (d1),
    .rsp_valid    (rsp_valid),
    .rsp_err      (rsp_err),
    .rsp_rdata    (rsp_rdata),
    .MemWrite     (MemWrite),
    .MemMode      (MemMode),
    .memAddr      (memAddr),
    .memWriteData (memWriteData),
    .memReadData  (memReadData)
  );

  logic [31:0] mem    [0:16383];
  logic [31:0] refMem [0:16383];
  logic [31:0] rdWord;
  logic [7:0]  rdByte;

  assign rdWord = mem[memAddr[15:2]];
  assign rdByte = rdWord[{memAddr[1:0], 3'b000} +: 8];

  always_comb begin
    memReadData = '0;
    case (MemMode)
      2'b00:   memReadData = rdWord;
      2'b01:   memReadData = {{24{rdByte[7]}}, rdByte};
      2'b10:   memReadData = {24'h0, rdByte};
      default: memReadData = '0;
    endcase
  end

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 32'hC0DE0000 + i;
    forever begin
      @(posedge clk);
      if (MemWrite) mem[memAddr[15:2]] <= memWriteData;
    end
  end

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          lat;
    int          acc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   grantLog[$];
  int   rspLog0[$];
  int   cyc = 0;
  int   nChecks = 0;
  int   nPass = 0;
  int   wrCount = 0;
  int   addrCount = 0;
  logic [15:0] lastWrAddr = '0;
  logic [31:0] lastWrData = '0;
  logic [15:0] lastPrevAddr = '0;
  logic [15:0] prevAddr = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic exp_t predict(input logic w, input logic [1:0] m,
                                   input logic [15:0] a,
                                   input logic [31:0] d);
    exp_t        e;
    logic [31:0] word;
    logic [7:0]  b;
    int          idx;
    idx = int'(a[15:2]);
    e.err = (m == 2'b11) || (m == 2'b00 && a[1:0] != 2'b00)
         || (w && a[15:12] == 4'h0) || (w && m == 2'b01);
    e.rdata = '0;
    e.acc = 0;
    word = refMem[idx];
    b = word[a[1:0]*8 +: 8];
    if (e.err) e.lat = 1;
    else if (w && m == 2'b00) begin
      refMem[idx] = d;
      e.lat = 2;
    end else if (w) begin
      word[a[1:0]*8 +: 8] = d[7:0];
      refMem[idx] = word;
      e.lat = 3;
    end else begin
      e.lat = 2;
      if (m == 2'b00) e.rdata = word;
      else if (m == 2'b01) e.rdata = {{24{b[7]}}, b};
      else e.rdata = {24'h0, b};
    end
    return e;
  endfunction

  task automatic issue(input int p, input logic w, input logic [1:0] m,
                       input logic [15:0] a, input logic [31:0] d,
                       input bit hold);
    exp_t e;
    bit   got;
    got = 1'b0;
    if (p == 0) begin
      v0 = 1'b1; w0 = w; m0 = m; a0 = a; d0 = d;
    end else begin
      v1 = 1'b1; w1 = w; m1 = m; a1 = a; d1 = d;
    end
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      got = req_ready[p];
    end
    if (!got) begin
      chk($sformatf("acceptTimeout%0d", p), {31'h0, got}, 1);
      if (p == 0) v0 = 1'b0; else v1 = 1'b0;
      return;
    end
    e = predict(w, m, a, d);
    e.acc = cyc + 1;
    if (p == 0) q0.push_back(e); else q1.push_back(e);
    grantLog.push_back(p);
    @(posedge clk);
    #1;
    if (!hold) begin
      if (p == 0) v0 = 1'b0; else v1 = 1'b0;
    end
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(posedge clk);
      ok = (q0.size() == 0 && q1.size() == 0);
    end
    chk("drain", {31'h0, ok}, 1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic takeRsp(input int p);
    exp_t e;
    bit   empty;
    empty = (p == 0) ? (q0.size() == 0) : (q1.size() == 0);
    if (empty) begin
      chk($sformatf("rspUnexpected%0d", p), {31'h0, rsp_valid[p]}, 0);
    end else begin
      if (p == 0) e = q0.pop_front(); else e = q1.pop_front();
      chk($sformatf("rspErr%0d", p), {31'h0, rsp_err}, {31'h0, e.err});
      chk($sformatf("rspData%0d", p), rsp_rdata, e.rdata);
      chk($sformatf("rspLat%0d", p), cyc - e.acc + 1, e.lat);
      if (p == 0) rspLog0.push_back(cyc);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (MemWrite) begin
        wrCount++;
        lastWrAddr = memAddr;
        lastWrData = memWriteData;
        lastPrevAddr = prevAddr;
      end
      if (memAddr != 16'h0) addrCount++;
      prevAddr = memAddr;
      if (rsp_valid[0]) takeRsp(0);
      if (rsp_valid[1]) takeRsp(1);
    end
  end

  int wc;
  int ac;

  initial begin
    for (int i = 0; i < 16384; i++) refMem[i] = 32'hC0DE0000 + i;

    repeat (3) @(posedge clk);
    #1;
    chk("rstRspValid", {30'h0, rsp_valid}, 0);
    chk("rstRspErr", {31'h0, rsp_err}, 0);
    chk("rstRdata", rsp_rdata, 0);
    chk("rstMemWrite", {31'h0, MemWrite}, 0);
    chk("rstMemMode", {30'h0, MemMode}, 0);
    chk("rstMemAddr", {16'h0, memAddr}, 0);
    chk("rstWdata", memWriteData, 0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("idleReady", {30'h0, req_ready}, 0);

    grantLog.delete();
    fork
      begin
        issue(0, 1'b0, 2'b00, 16'h0000, 32'h0, 1'b1);
        issue(0, 1'b0, 2'b00, 16'h0004, 32'h0, 1'b1);
        issue(0, 1'b0, 2'b10, 16'h0003, 32'h0, 1'b0);
      end
      begin
        issue(1, 1'b0, 2'b00, 16'h0100, 32'h0, 1'b1);
        issue(1, 1'b0, 2'b01, 16'h0102, 32'h0, 1'b1);
        issue(1, 1'b0, 2'b00, 16'hF000, 32'h0, 1'b0);
      end
    join
    drain();
    chk("rrCount", grantLog.size(), 6);
    for (int i = 0; i < grantLog.size(); i++)
      chk($sformatf("rrGrant%0d", i), grantLog[i], i % 2);

    wc = wrCount;
    issue(0, 1'b1, 2'b00, 16'h1000, 32'hDEADBEEF, 1'b0);
    drain();
    chk("wstWrites", wrCount - wc, 1);
    chk("wstAddr", {16'h0, lastWrAddr}, 32'h1000);
    chk("wstData", lastWrData, 32'hDEADBEEF);
    issue(0, 1'b0, 2'b00, 16'h1000, 32'h0, 1'b0);
    drain();

    issue(0, 1'b1, 2'b00, 16'h1004, 32'h11223344, 1'b0);
    drain();
    wc = wrCount;
    issue(1, 1'b1, 2'b10, 16'h1006, 32'hFFFFFFAB, 1'b0);
    drain();
    chk("rmwWrites", wrCount - wc, 1);
    chk("rmwRdAddr", {16'h0, lastPrevAddr}, 32'h1004);
    chk("rmwWrAddr", {16'h0, lastWrAddr}, 32'h1004);
    chk("rmwWrData", lastWrData, 32'h11AB3344);
    issue(1, 1'b0, 2'b01, 16'h1006, 32'h0, 1'b0);
    issue(1, 1'b0, 2'b10, 16'h1006, 32'h0, 1'b0);
    issue(0, 1'b1, 2'b10, 16'hF001, 32'h0000005A, 1'b0);
    issue(0, 1'b0, 2'b00, 16'hF000, 32'h0, 1'b0);
    issue(1, 1'b1, 2'b10, 16'h1013, 32'h00000080, 1'b0);
    issue(1, 1'b0, 2'b01, 16'h1013, 32'h0, 1'b0);
    drain();

    wc = wrCount;
    ac = addrCount;
    issue(0, 1'b0, 2'b00, 16'h1002, 32'h0, 1'b0);
    issue(1, 1'b1, 2'b00, 16'h0010, 32'h12345678, 1'b0);
    issue(0, 1'b0, 2'b11, 16'h1000, 32'h0, 1'b0);
    issue(1, 1'b1, 2'b01, 16'h1008, 32'h0, 1'b0);
    drain();
    chk("errWrites", wrCount - wc, 0);
    chk("errAddrActivity", addrCount - ac, 0);

    wc = wrCount;
    v1 = 1'b1; w1 = 1'b1; m1 = 2'b10; a1 = 16'h1005; d1 = 32'h5A;
    begin
      bit got;
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
        @(negedge clk);
        got = req_ready[1];
      end
      chk("abortAccept", {31'h0, got}, 1);
    end
    @(posedge clk);
    #1;
    v1 = 1'b0;
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("abortMemWrite", {31'h0, MemWrite}, 0);
    chk("abortMemAddr", {16'h0, memAddr}, 0);
    chk("abortRspValid", {30'h0, rsp_valid}, 0);
    reset = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("abortWrites", wrCount - wc, 0);
    chk("abortRamWord", mem[16'h1004 >> 2], 32'h11AB3344);
    issue(1, 1'b0, 2'b00, 16'h1004, 32'h0, 1'b0);
    drain();

    rspLog0.delete();
    issue(0, 1'b0, 2'b00, 16'h0000, 32'h0, 1'b1);
    issue(0, 1'b0, 2'b00, 16'h0004, 32'h0, 1'b1);
    issue(0, 1'b0, 2'b00, 16'h0008, 32'h0, 1'b0);
    drain();
    chk("b2bCount", rspLog0.size(), 3);
    if (rspLog0.size() == 3) begin
      chk("b2bGap1", rspLog0[1] - rspLog0[0], 3);
      chk("b2bGap2", rspLog0[2] - rspLog0[1], 3);
    end

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
